// File: rtl/message_schedule.sv
// SHA-256 message schedule: loads 16 words, expands them in place to W[0..63],
// then holds the schedule for round_operations until it is released.
//
// state  | meaning
// -------+------------------------------------------------------------
// LOAD   | accepting message words W[0..15] into the array
// EXPAND | computing W[16..63], one word per cycle
// READY  | schedule complete and frozen, waiting for release_req
module message_schedule #(
    parameter int WORD_SIZE = 32,
    parameter int ROUNDS    = 64
) (
    input  logic                 clock,
    input  logic                 clear_n,
    input  logic [WORD_SIZE-1:0] word_in,
    input  logic                 word_valid,
    output logic                 word_accept,
    input  logic [5:0]           message_schedule_index,
    output logic [WORD_SIZE-1:0] message_schedule_value,
    output logic                 schedule_ready,
    input  logic                 release_req
);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [6:0]           cnt;
    logic [WORD_SIZE-1:0] w [ROUNDS];
    logic [WORD_SIZE-1:0] w_new;
    logic [5:0]           idx;

    function automatic logic [WORD_SIZE-1:0] rotr(input logic [WORD_SIZE-1:0] x,
                                                  input int unsigned n);
        return (x >> n) | (x << (WORD_SIZE - n));
    endfunction

    function automatic logic [WORD_SIZE-1:0] sigma0(input logic [WORD_SIZE-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_SIZE-1:0] sigma1(input logic [WORD_SIZE-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    assign idx = cnt[5:0];

    // Operand indices wrap in 6 bits but are only used while cnt >= 16,
    // so every operand was written on an earlier edge.
    assign w_new = sigma1(w[idx - 6'd2]) + w[idx - 6'd7]
                 + sigma0(w[idx - 6'd15]) + w[idx - 6'd16];

    assign word_accept            = (state == LOAD);
    assign message_schedule_value = w[message_schedule_index];

    // State register.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            LOAD: begin
                if (word_valid && cnt == 7'd15) begin
                    state_next = EXPAND;
                end
            end
            EXPAND: begin
                if (cnt == 7'd63) begin
                    state_next = READY;
                end
            end
            READY: begin
                if (release_req) begin
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // Ready flag registered from the next state so it tracks READY exactly.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            schedule_ready <= 1'b0;
        end else begin
            schedule_ready <= (state_next == READY);
        end
    end

    // Word counter: load/expand write pointer, cleared on entry to READY and LOAD.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            cnt <= 7'd0;
        end else begin
            case (state)
                LOAD: begin
                    if (word_valid) begin
                        cnt <= cnt + 7'd1;
                    end
                end
                EXPAND: begin
                    if (cnt == 7'd63) begin
                        cnt <= 7'd0;
                    end else begin
                        cnt <= cnt + 7'd1;
                    end
                end
                READY: begin
                    cnt <= 7'd0;
                end
                default: cnt <= 7'd0;
            endcase
        end
    end

    // Schedule array: written by loads and expansion, frozen in READY.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < ROUNDS; i++) begin
                w[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (word_valid) begin
                        w[idx] <= word_in;
                    end
                end
                EXPAND: begin
                    w[idx] <= w_new;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_message_schedule.sv
// Self-checking bench for message_schedule: reference schedule model feeding a
// scoreboard queue that is drained against the read port once the block is ready.
module tb_message_schedule;

    logic        clock;
    logic        clear_n;
    logic [31:0] word_in;
    logic        word_valid;
    logic        word_accept;
    logic [5:0]  message_schedule_index;
    logic [31:0] message_schedule_value;
    logic        schedule_ready;
    logic        release_req;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] blk [16];

    message_schedule #(.WORD_SIZE(32), .ROUNDS(64)) dut (
        .clock                  (clock),
        .clear_n                (clear_n),
        .word_in                (word_in),
        .word_valid             (word_valid),
        .word_accept            (word_accept),
        .message_schedule_index (message_schedule_index),
        .message_schedule_value (message_schedule_value),
        .schedule_ready         (schedule_ready),
        .release_req            (release_req)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    // Reference schedule for blk[], pushed to the scoreboard in read order.
    task automatic push_expected();
        logic [31:0] m [64];
        logic [31:0] s0, s1;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                m[t] = blk[t];
            end else begin
                s0 = ror(m[t-15], 7) ^ ror(m[t-15], 18) ^ (m[t-15] >> 3);
                s1 = ror(m[t-2], 17) ^ ror(m[t-2], 19) ^ (m[t-2] >> 10);
                m[t] = s1 + m[t-7] + s0 + m[t-16];
            end
            sb_q.push_back('{idx: t, val: m[t]});
        end
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
    endtask

    task automatic check_zero_all(input string tag);
        for (int t = 0; t < 64; t++) begin
            message_schedule_index = 6'(t);
            #1;
            chk($sformatf("%s_w%0d", tag, t), message_schedule_value, 32'h0);
        end
    endtask

    // Streams blk[] (optionally gapped), optionally pokes ignored inputs, and
    // measures edges from the W[15] accept edge to schedule_ready.
    // abort_at > 0 asserts clear_n after that many expansion edges.
    task automatic load_block(input bit gapped, input bit poke, input int abort_at);
        int n;
        push_expected();
        for (int i = 0; i < 16; i++) begin
            if (gapped) begin
                int g;
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    word_valid = 1'b0;
                    word_in    = 32'hFFFF0000 | 32'(k);
                    @(posedge clock); #1;
                end
            end
            word_valid  = 1'b1;
            word_in     = blk[i];
            release_req = poke && (i % 3 == 1);
            chk("accept_load", {31'b0, word_accept}, 32'd1);
            @(posedge clock); #1;
        end
        word_valid  = 1'b0;
        release_req = 1'b0;
        n = 0;
        while (n < 100 && !schedule_ready) begin
            if (abort_at > 0 && n == abort_at) begin
                clear_n = 1'b0;
                #1;
                chk("abort_accept", {31'b0, word_accept}, 32'd1);
                chk("abort_ready", {31'b0, schedule_ready}, 32'd0);
                check_zero_all("abort");
                sb_q.delete();
                @(negedge clock);
                clear_n = 1'b1;
                @(posedge clock); #1;
                return;
            end
            if (poke && n < 40) begin
                word_valid  = 1'b1;
                word_in     = 32'hA5A50000 | 32'(n);
                release_req = 1'b1;
                chk("accept_expand", {31'b0, word_accept}, 32'd0);
            end else begin
                word_valid  = 1'b0;
                release_req = 1'b0;
            end
            @(posedge clock); #1;
            n++;
        end
        word_valid  = 1'b0;
        release_req = 1'b0;
        chk("ready_latency", 32'(n), 32'd48);
        if (poke) begin
            for (int k = 0; k < 3; k++) begin
                word_valid = 1'b1;
                word_in    = 32'hCAFE0000 | 32'(k);
                chk("accept_ready", {31'b0, word_accept}, 32'd0);
                @(posedge clock); #1;
                chk("ready_hold", {31'b0, schedule_ready}, 32'd1);
            end
            word_valid = 1'b0;
        end
    endtask

    task automatic drain_scoreboard();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            message_schedule_index = 6'(e.idx);
            #1;
            chk($sformatf("w%0d", e.idx), message_schedule_value, e.val);
        end
    endtask

    task automatic check_abc_consts();
        message_schedule_index = 6'd16; #1;
        chk("abc_w16", message_schedule_value, 32'h61626380);
        message_schedule_index = 6'd17; #1;
        chk("abc_w17", message_schedule_value, 32'h000F0000);
        message_schedule_index = 6'd63; #1;
        chk("abc_w63", message_schedule_value, 32'h12B1EDEB);
    endtask

    task automatic release_with_word();
        @(posedge clock); #1;
        release_req = 1'b1;
        word_valid  = 1'b1;
        word_in     = 32'hBAD0BAD0;
        chk("rel_accept_before", {31'b0, word_accept}, 32'd0);
        @(posedge clock); #1;
        release_req = 1'b0;
        word_valid  = 1'b0;
        chk("rel_ready", {31'b0, schedule_ready}, 32'd0);
        chk("rel_accept", {31'b0, word_accept}, 32'd1);
    endtask

    initial begin
        clear_n                = 1'b0;
        word_in                = '0;
        word_valid             = 1'b0;
        release_req            = 1'b0;
        message_schedule_index = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_accept", {31'b0, word_accept}, 32'd1);
        chk("rst_ready", {31'b0, schedule_ready}, 32'd0);
        @(negedge clock);
        clear_n = 1'b1;
        @(posedge clock); #1;

        // Partial block, then reset mid-stream.
        for (int i = 0; i < 5; i++) begin
            word_valid = 1'b1;
            word_in    = $urandom | 32'h1;
            @(posedge clock); #1;
        end
        word_valid = 1'b0;
        clear_n    = 1'b0;
        #1;
        chk("mid_rst_accept", {31'b0, word_accept}, 32'd1);
        chk("mid_rst_ready", {31'b0, schedule_ready}, 32'd0);
        check_zero_all("mid_rst");
        @(negedge clock);
        clear_n = 1'b1;
        @(posedge clock); #1;

        // "abc" back-to-back with ignored inputs in every state.
        set_abc();
        load_block(1'b0, 1'b1, 0);
        drain_scoreboard();
        check_abc_consts();

        // Release together with a word, then a random gapped block.
        release_with_word();
        set_random();
        load_block(1'b1, 1'b0, 0);
        drain_scoreboard();

        // "abc" again, gapped.
        release_with_word();
        set_abc();
        load_block(1'b1, 1'b0, 0);
        drain_scoreboard();
        check_abc_consts();

        // Abort at cnt=40, then a clean "abc" load.
        release_with_word();
        set_random();
        load_block(1'b0, 1'b0, 24);
        set_abc();
        load_block(1'b0, 1'b0, 0);
        drain_scoreboard();
        check_abc_consts();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
